bullet_pool: RTL

- Manages a pool of up to NUM_BULLETS simultaneous bullets for one tank.
- Handles fire requests, free-slot allocation, fire cooldown, fixed-point motion, wall bounce, finite lifetime, and kill-on-hit.
- Sits between the tank controller (position, angle sin/cos, fire key) and the collision and drawing logic.
- Collision logic returns per-slot wall and hit flags; the drawing logic consumes per-slot positions.

---
 rtl/bullet_pool.sv | 133 +++++++++++++
 1 files changed

// File: rtl/bullet_pool.sv
// bullet_pool: fixed-point bullet slots for one tank, with fire cooldown,
// lowest-free-slot allocation, wall bounce, finite lifetime and kill-on-hit.
module bullet_pool #(
    parameter int NUM_BULLETS     = 3,
    parameter int POS_W           = 10,
    parameter int FRAC_W          = 6,
    parameter int SPEED           = 2,
    parameter int LIFE_FRAMES     = 240,
    parameter int COOLDOWN_FRAMES = 15,
    parameter int BULLET_SIZE     = 4
) (
    input  logic                         frame_clk,
    input  logic                         Reset,
    input  logic                         fire,
    input  logic [POS_W-1:0]             tankX,
    input  logic [POS_W-1:0]             tankY,
    input  logic [7:0]                   sin,
    input  logic [7:0]                   cos,
    input  logic [NUM_BULLETS-1:0]       wall_hit_x,
    input  logic [NUM_BULLETS-1:0]       wall_hit_y,
    input  logic [NUM_BULLETS-1:0]       kill,
    output logic [NUM_BULLETS-1:0]       active,
    output logic [NUM_BULLETS*POS_W-1:0] bullet_x,
    output logic [NUM_BULLETS*POS_W-1:0] bullet_y,
    output logic [POS_W-1:0]             bullet_size,
    output logic                         fire_accepted,
    output logic                         pool_full
);
    localparam int VW = POS_W + FRAC_W;
    localparam int LW = $clog2(LIFE_FRAMES + 1);
    localparam int CW = COOLDOWN_FRAMES > 0 ? $clog2(COOLDOWN_FRAMES + 1) : 1;
    localparam int SW = NUM_BULLETS > 1 ? $clog2(NUM_BULLETS) : 1;

    logic [NUM_BULLETS-1:0] active_q, active_d;
    logic [VW-1:0]          px_q [NUM_BULLETS];
    logic [VW-1:0]          px_d [NUM_BULLETS];
    logic [VW-1:0]          py_q [NUM_BULLETS];
    logic [VW-1:0]          py_d [NUM_BULLETS];
    logic [VW-1:0]          vx_q [NUM_BULLETS];
    logic [VW-1:0]          vx_d [NUM_BULLETS];
    logic [VW-1:0]          vy_q [NUM_BULLETS];
    logic [VW-1:0]          vy_d [NUM_BULLETS];
    logic [LW-1:0]          life_q [NUM_BULLETS];
    logic [LW-1:0]          life_d [NUM_BULLETS];
    logic [CW-1:0]          cool_q, cool_d;
    logic                   fire_prev_q, fire_acc_q;
    logic                   launch;
    logic [SW-1:0]          slot;
    logic [VW-1:0]          vx_launch, vy_launch;

    // Allocation looks only at the pre-edge state, so a slot retired this frame stays unavailable.
    always_comb begin
        slot = '0;
        for (int i = NUM_BULLETS - 1; i >= 0; i--)
            if (!active_q[i]) slot = SW'(i);
        launch    = fire & ~fire_prev_q & (cool_q == '0) & ~&active_q;
        vx_launch = {{(VW-8){cos[7]}}, cos} * VW'(SPEED);
        vy_launch = {{(VW-8){sin[7]}}, sin} * VW'(SPEED);
        cool_d    = launch ? CW'(COOLDOWN_FRAMES) : (cool_q != '0 ? cool_q - 1'b1 : cool_q);
    end

    // Kill beats expiry beats motion; position uses the already-reflected velocity.
    always_comb begin
        active_d = active_q;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            px_d[i]   = px_q[i];
            py_d[i]   = py_q[i];
            vx_d[i]   = vx_q[i];
            vy_d[i]   = vy_q[i];
            life_d[i] = life_q[i];
            if (active_q[i]) begin
                if (kill[i] || life_q[i] == LW'(1)) begin
                    active_d[i] = 1'b0;
                end else begin
                    life_d[i] = life_q[i] - 1'b1;
                    vx_d[i]   = wall_hit_x[i] ? -vx_q[i] : vx_q[i];
                    vy_d[i]   = wall_hit_y[i] ? -vy_q[i] : vy_q[i];
                    px_d[i]   = px_q[i] + vx_d[i];
                    py_d[i]   = py_q[i] + vy_d[i];
                end
            end else if (launch && slot == SW'(i)) begin
                active_d[i] = 1'b1;
                px_d[i]     = {tankX, {FRAC_W{1'b0}}};
                py_d[i]     = {tankY, {FRAC_W{1'b0}}};
                vx_d[i]     = vx_launch;
                vy_d[i]     = vy_launch;
                life_d[i]   = LW'(LIFE_FRAMES);
            end
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            active_q    <= '0;
            cool_q      <= '0;
            fire_prev_q <= 1'b0;
            fire_acc_q  <= 1'b0;
            for (int i = 0; i < NUM_BULLETS; i++) begin
                px_q[i]   <= '0;
                py_q[i]   <= '0;
                vx_q[i]   <= '0;
                vy_q[i]   <= '0;
                life_q[i] <= '0;
            end
        end else begin
            active_q    <= active_d;
            cool_q      <= cool_d;
            fire_prev_q <= fire;
            fire_acc_q  <= launch;
            for (int i = 0; i < NUM_BULLETS; i++) begin
                px_q[i]   <= px_d[i];
                py_q[i]   <= py_d[i];
                vx_q[i]   <= vx_d[i];
                vy_q[i]   <= vy_d[i];
                life_q[i] <= life_d[i];
            end
        end
    end

    always_comb begin
        bullet_x = '0;
        bullet_y = '0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            bullet_x[i*POS_W +: POS_W] = active_q[i] ? px_q[i][VW-1:FRAC_W] : '0;
            bullet_y[i*POS_W +: POS_W] = active_q[i] ? py_q[i][VW-1:FRAC_W] : '0;
        end
    end

    assign active        = active_q;
    assign fire_accepted = fire_acc_q;
    assign pool_full     = &active_q;
    assign bullet_size   = POS_W'(BULLET_SIZE);
endmodule
